// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate unit: operand widths and the
// encodings of the two feedback mux selects and the arithmetic mode.
package mac_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 17;

    localparam logic MUL_SEL_IN  = 1'b0;
    localparam logic MUL_SEL_FB  = 1'b1;

    localparam logic ADD_SEL_IN  = 1'b0;
    localparam logic ADD_SEL_ACC = 1'b1;

    localparam logic MODE_SOP    = 1'b0;
    localparam logic MODE_HORNER = 1'b1;

endpackage : mac_pkg

// File: rtl/mac_mul_add.sv
// Combinational MAC datapath: operand feedback muxes, full-width multiply and
// add, then modulo wrap (Horner mode) or saturation (sum-of-products mode).
module mac_mul_add #(
    parameter int IN_W  = mac_pkg::IN_W,
    parameter int OUT_W = mac_pkg::OUT_W
) (
    input  logic [IN_W-1:0]  i_in_1,
    input  logic [IN_W-1:0]  i_in_2,
    input  logic [IN_W-1:0]  i_in_add,
    input  logic             i_mode,
    input  logic             i_mul_sel,
    input  logic             i_add_sel,
    input  logic [OUT_W-1:0] i_acc,
    output logic [OUT_W-1:0] o_next
);
    import mac_pkg::*;

    localparam int PROD_W = OUT_W + IN_W;
    localparam int SUM_W  = PROD_W + 1;

    logic [OUT_W-1:0]  w_op_a;
    logic [OUT_W-1:0]  w_addend;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic              w_overflow;

    assign w_op_a   = (i_mul_sel == MUL_SEL_FB)  ? i_acc : {{(OUT_W-IN_W){1'b0}}, i_in_1};
    assign w_addend = (i_add_sel == ADD_SEL_ACC) ? i_acc : {{(OUT_W-IN_W){1'b0}}, i_in_add};

    // Widths are chosen so neither the product nor the sum can lose a carry.
    assign w_prod = PROD_W'(w_op_a) * PROD_W'(i_in_2);
    assign w_sum  = SUM_W'(w_prod) + SUM_W'(w_addend);

    assign w_overflow = |w_sum[SUM_W-1:OUT_W];

    assign o_next = (i_mode == MODE_HORNER) ? w_sum[OUT_W-1:0]
                  : (w_overflow ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0]);

endmodule : mac_mul_add

// File: rtl/mac_mac_unit.sv
// Multiply-accumulate unit top: a single result register fed by the
// combinational mac_mul_add datapath, with synchronous active-low reset.
module mac_mac_unit #(
    parameter int IN_W  = mac_pkg::IN_W,
    parameter int OUT_W = mac_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_1,
    input  logic [IN_W-1:0]  in_2,
    input  logic [IN_W-1:0]  in_add,
    input  logic             mode,
    input  logic             mul_input_mux,
    input  logic             adder_input_mux,
    output logic [OUT_W-1:0] mac_output
);
    import mac_pkg::*;

    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_next;

    mac_mul_add #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mul_add (
        .i_in_1    (in_1),
        .i_in_2    (in_2),
        .i_in_add  (in_add),
        .i_mode    (mode),
        .i_mul_sel (mul_input_mux),
        .i_add_sel (adder_input_mux),
        .i_acc     (r_acc),
        .o_next    (w_next)
    );

    // NOTE: state updates use non-blocking assignment so every reader of r_acc
    // in this edge sees the pre-edge value; reset is sampled on the edge only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_next;
        end
    end

    assign mac_output = r_acc;

endmodule : mac_mac_unit

// File: tb/tb_mac_mac_unit.sv
// Self-checking bench for mac_mac_unit: directed Horner, sum-of-products and
// saturation scenarios plus randomized cycles against an arithmetic model.
module tb_mac_mac_unit;
    import mac_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  in_1, in_2, in_add;
    logic             mode, mul_input_mux, adder_input_mux;
    logic [OUT_W-1:0] mac_output;

    int     checks = 0;
    int     errors = 0;
    longint model_acc = 0;

    localparam longint LIMIT = longint'(1) << OUT_W;

    always #5 clk = ~clk;

    mac_mac_unit dut (
        .clk             (clk),
        .reset           (reset),
        .in_1            (in_1),
        .in_2            (in_2),
        .in_add          (in_add),
        .mode            (mode),
        .mul_input_mux   (mul_input_mux),
        .adder_input_mux (adder_input_mux),
        .mac_output      (mac_output)
    );

    // Reference: one register update computed with plain integer arithmetic.
    function automatic longint ref_next(longint acc, longint a, longint x, longint b,
                                        bit m, bit fb, bit use_acc);
        longint s;
        s = (fb ? acc : a) * x + (use_acc ? acc : b);
        if (m) return s % LIMIT;
        return (s >= LIMIT) ? LIMIT - 1 : s;
    endfunction

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic step(input bit r, input int a, input int x, input int b,
                        input bit m, input bit fb, input bit use_acc);
        reset           = r;
        in_1            = IN_W'(a);
        in_2            = IN_W'(x);
        in_add          = IN_W'(b);
        mode            = m;
        mul_input_mux   = fb;
        adder_input_mux = use_acc;
        @(posedge clk);
        if (!r) model_acc = 0;
        else    model_acc = ref_next(model_acc, a, x, b, m, fb, use_acc);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(255)), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (mac_output !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, mac_output);
            end
        end
        step(1'b1, 5, 3, 2, MODE_HORNER, MUL_SEL_IN, ADD_SEL_IN);
        step(1'b0, 0, 3, 1, MODE_HORNER, MUL_SEL_FB, ADD_SEL_IN);
        checks++;
        if (mac_output !== '0) begin
            errors++;
            $display("FAIL reset_mid_sequence: got %0d expected 0", mac_output);
        end
    endtask

    task automatic test_horner();
        int a[2] = '{5, 9};
        int x[2] = '{3, 8};
        int b[2] = '{2, 7};
        int c[2] = '{1, 6};
        int e1, e2;
        for (int i = 0; i < 2; i++) begin
            e1 = a[i] * x[i] + b[i];
            e2 = e1 * x[i] + c[i];
            step(1'b1, a[i], x[i], b[i], MODE_HORNER, MUL_SEL_IN, ADD_SEL_IN);
            checks++;
            if (mac_output !== OUT_W'(e1)) begin
                errors++;
                $display("FAIL horner_stage1[%0d]: got %0d expected %0d", i, mac_output, e1);
            end
            step(1'b1, 0, x[i], c[i], MODE_HORNER, MUL_SEL_FB, ADD_SEL_IN);
            checks++;
            if (mac_output !== OUT_W'(e2)) begin
                errors++;
                $display("FAIL horner_stage2[%0d]: got %0d expected %0d", i, mac_output, e2);
            end
        end
    endtask

    task automatic test_horner_wrap();
        longint e1, e2;
        e1 = 255 * 255 + 255;
        e2 = (e1 * 255 + 255) % LIMIT;
        step(1'b1, 255, 255, 255, MODE_HORNER, MUL_SEL_IN, ADD_SEL_IN);
        checks++;
        if (mac_output !== OUT_W'(e1)) begin
            errors++;
            $display("FAIL horner_wrap_stage1: got %0d expected %0d", mac_output, e1);
        end
        step(1'b1, 0, 255, 255, MODE_HORNER, MUL_SEL_FB, ADD_SEL_IN);
        checks++;
        if (mac_output !== OUT_W'(e2)) begin
            errors++;
            $display("FAIL horner_wrap_stage2: got %0d expected %0d", mac_output, e2);
        end
    endtask

    task automatic test_sum_of_products();
        int a[3]   = '{5, 9, 0};
        int x[3]   = '{3, 8, 200};
        int exp[3] = '{15, 87, 87};
        step(1'b0, 0, 0, 0, MODE_SOP, MUL_SEL_IN, ADD_SEL_ACC);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, a[i], x[i], int'($urandom_range(255)), MODE_SOP, MUL_SEL_IN, ADD_SEL_ACC);
            checks++;
            if (mac_output !== OUT_W'(exp[i])) begin
                errors++;
                $display("FAIL sop[%0d]: got %0d expected %0d", i, mac_output, exp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp[5] = '{65025, 130050, 131071, 131071, 131071};
        step(1'b0, 0, 0, 0, MODE_SOP, MUL_SEL_IN, ADD_SEL_ACC);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 255, 255, 0, MODE_SOP, MUL_SEL_IN, ADD_SEL_ACC);
            checks++;
            if (mac_output !== OUT_W'(exp[i])) begin
                errors++;
                $display("FAIL saturate[%0d]: got %0d expected %0d", i, mac_output, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        bit r;
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(31) != 0);
            step(r, int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(255)), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (mac_output !== OUT_W'(model_acc)) begin
                errors++;
                $display("FAIL random[%0d]: got %0d expected %0d", i, mac_output, model_acc);
            end
        end
    endtask

    initial begin
        reset = 1'b0; in_1 = '0; in_2 = '0; in_add = '0;
        mode = MODE_SOP; mul_input_mux = MUL_SEL_IN; adder_input_mux = ADD_SEL_IN;
        @(negedge clk);
        test_reset();
        test_horner();
        test_horner_wrap();
        test_sum_of_products();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mac_mac_unit
